// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 write-response types and response codes
package axi4_pkg;
  localparam int AXI_ID_W = 4;
  localparam int AXI_LEN_W = 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [AXI_LEN_W-1:0] len;
  } aw_info_t;
  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0] resp;
  } b_info_t;
endpackage

// File: rtl/axi4_sync_fifo.sv
// axi4_sync_fifo: generic synchronous FIFO; a push while full is dropped even if a pop coincides
module axi4_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/axi4_write_response_gen.sv
// axi4_write_response_gen: checks W beat counts against AWLEN and issues B responses
module axi4_write_response_gen
  import axi4_pkg::*;
#(
  parameter int ID_W = AXI_ID_W,
  parameter int LEN_W = AXI_LEN_W,
  parameter int DEPTH = 4
) (
  input  logic             io_clk,
  input  logic             io_rstn,
  input  logic             io_awvalid,
  input  logic             io_awready,
  input  logic [ID_W-1:0]  io_awid,
  input  logic [LEN_W-1:0] io_awlen,
  input  logic             io_wvalid,
  input  logic             io_wready,
  input  logic             io_wlast,
  output logic             io_bvalid,
  input  logic             io_bready,
  output logic [ID_W-1:0]  io_bid,
  output logic [1:0]       io_bresp,
  output logic             io_aw_full,
  output logic             io_w_stall,
  output logic             io_proto_err
);
  aw_info_t aw_new, aw_head;
  b_info_t b_new, b_head;
  logic aw_push, w_beat, w_ok, w_done, bad_len, too_long;
  logic aw_full, aw_empty, b_full, b_empty;
  logic [LEN_W:0] beat_cnt;
  logic burst_err, proto_err;
  assign aw_push = io_awvalid & io_awready;
  assign w_beat = io_wvalid & io_wready;
  assign w_ok = w_beat & ~aw_empty;
  assign w_done = w_ok & io_wlast;
  assign bad_len = beat_cnt != {1'b0, aw_head.len};
  // a non-last beat landing on the final expected slot means the burst overruns AWLEN
  assign too_long = w_ok & ~io_wlast & ~bad_len;
  assign aw_new = '{id: io_awid, len: io_awlen};
  assign b_new = '{id: aw_head.id, resp: (burst_err | bad_len) ? RESP_SLVERR : RESP_OKAY};
  axi4_sync_fifo #(.WIDTH($bits(aw_info_t)), .DEPTH(DEPTH)) u_aw_fifo (
    .clk(io_clk), .rst_n(io_rstn), .push(aw_push), .din(aw_new), .pop(w_done),
    .full(aw_full), .empty(aw_empty), .head(aw_head)
  );
  axi4_sync_fifo #(.WIDTH($bits(b_info_t)), .DEPTH(DEPTH)) u_b_fifo (
    .clk(io_clk), .rst_n(io_rstn), .push(w_done), .din(b_new), .pop(io_bready),
    .full(b_full), .empty(b_empty), .head(b_head)
  );
  always_ff @(posedge io_clk or negedge io_rstn)
    if (!io_rstn) begin
      beat_cnt <= '0;
      burst_err <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (w_done) begin
        beat_cnt <= '0;
        burst_err <= 1'b0;
      end else if (w_ok) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (too_long) burst_err <= 1'b1;
      end
      if ((aw_push & aw_full) | (w_beat & aw_empty) | (w_done & b_full)) proto_err <= 1'b1;
    end
  assign io_bvalid = ~b_empty;
  assign io_bid = b_empty ? '0 : b_head.id;
  assign io_bresp = b_empty ? RESP_OKAY : b_head.resp;
  assign io_aw_full = aw_full;
  assign io_w_stall = b_full;
  assign io_proto_err = proto_err;
endmodule

// File: tb/tb_axi4_write_response_gen.sv
// tb_axi4_write_response_gen: table-driven, directed and randomized checks against a queue model
module tb_axi4_write_response_gen;
  localparam int DEPTH = 4;
  logic io_clk = 1'b0, io_rstn = 1'b0;
  logic io_awvalid = 1'b0, io_awready = 1'b0, io_wvalid = 1'b0, io_wready = 1'b0, io_wlast = 1'b0, io_bready = 1'b0;
  logic [3:0] io_awid = '0;
  logic [7:0] io_awlen = '0;
  logic io_bvalid, io_aw_full, io_w_stall, io_proto_err;
  logic [3:0] io_bid;
  logic [1:0] io_bresp;
  always #5 io_clk = ~io_clk;

  axi4_write_response_gen #(.ID_W(4), .LEN_W(8), .DEPTH(DEPTH)) dut (
    .io_clk(io_clk), .io_rstn(io_rstn), .io_awvalid(io_awvalid), .io_awready(io_awready),
    .io_awid(io_awid), .io_awlen(io_awlen), .io_wvalid(io_wvalid), .io_wready(io_wready),
    .io_wlast(io_wlast), .io_bvalid(io_bvalid), .io_bready(io_bready), .io_bid(io_bid),
    .io_bresp(io_bresp), .io_aw_full(io_aw_full), .io_w_stall(io_w_stall), .io_proto_err(io_proto_err)
  );

  typedef struct { logic [3:0] id; logic [7:0] len; } m_aw_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } m_b_t;
  typedef struct { logic aw; logic [3:0] id; logic [7:0] len; logic w; logic last; logic br; logic [9:0] exp; } vec_t;
  m_aw_t aw_q[$];
  m_b_t b_q[$];
  int beats;
  bit m_perr;
  int n_vec = 0, n_bad = 0;
  vec_t tbl[16];

  task automatic model_reset();
    aw_q.delete();
    b_q.delete();
    beats = 0;
    m_perr = 0;
  endtask

  // bursts are judged by total beat count versus AWLEN+1; all drops use pre-edge occupancy
  task automatic model_step();
    int aw_n, b_n;
    m_b_t r;
    m_aw_t a;
    aw_n = aw_q.size();
    b_n = b_q.size();
    if (b_n > 0 && io_bready) void'(b_q.pop_front());
    if (io_wvalid && io_wready) begin
      if (aw_n == 0) m_perr = 1;
      else begin
        beats++;
        if (io_wlast) begin
          r.id = aw_q[0].id;
          r.resp = (beats != int'(aw_q[0].len) + 1) ? 2'b10 : 2'b00;
          if (b_n == DEPTH) m_perr = 1;
          else b_q.push_back(r);
          void'(aw_q.pop_front());
          beats = 0;
        end
      end
    end
    if (io_awvalid && io_awready) begin
      if (aw_n == DEPTH) m_perr = 1;
      else begin
        a.id = io_awid;
        a.len = io_awlen;
        aw_q.push_back(a);
      end
    end
  endtask

  function automatic logic [9:0] obs();
    return {io_bvalid, io_bvalid ? io_bid : 4'h0, io_bvalid ? io_bresp : 2'b00, io_aw_full, io_w_stall, io_proto_err};
  endfunction

  function automatic logic [9:0] model_exp();
    logic bv;
    bv = b_q.size() != 0;
    return {bv, bv ? b_q[0].id : 4'h0, bv ? b_q[0].resp : 2'b00, aw_q.size() == DEPTH, b_q.size() == DEPTH, m_perr};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge io_clk);
  endtask

  task automatic drive(input logic aw, input logic [3:0] id, input logic [7:0] len, input logic w, input logic last, input logic br);
    io_awvalid = aw; io_awready = aw; io_awid = id; io_awlen = len;
    io_wvalid = w; io_wready = w; io_wlast = last; io_bready = br;
    tick();
  endtask

  task automatic do_reset();
    io_rstn = 1'b0;
    io_awvalid = 0; io_awready = 0; io_wvalid = 0; io_wready = 0; io_wlast = 0; io_bready = 0;
    model_reset();
    @(negedge io_clk);
    @(negedge io_clk);
    io_rstn = 1'b1;
  endtask

  function automatic vec_t mk(logic aw, logic [3:0] id, logic [7:0] len, logic w, logic last, logic br, logic [9:0] exp);
    vec_t v;
    v.aw = aw; v.id = id; v.len = len; v.w = w; v.last = last; v.br = br; v.exp = exp;
    return v;
  endfunction

  initial begin
    tbl[0] = mk(1, 3, 3, 0, 0, 1, 10'b0);
    tbl[1] = mk(0, 0, 0, 1, 0, 1, 10'b0);
    tbl[2] = mk(0, 0, 0, 1, 0, 1, 10'b0);
    tbl[3] = mk(0, 0, 0, 1, 0, 1, 10'b0);
    tbl[4] = mk(0, 0, 0, 1, 1, 1, 10'b1_0011_00_000);
    tbl[5] = mk(0, 0, 0, 0, 0, 1, 10'b0);
    tbl[6] = mk(1, 5, 3, 0, 0, 1, 10'b0);
    tbl[7] = mk(0, 0, 0, 1, 0, 1, 10'b0);
    tbl[8] = mk(0, 0, 0, 1, 0, 1, 10'b0);
    tbl[9] = mk(0, 0, 0, 1, 1, 1, 10'b1_0101_10_000);
    tbl[10] = mk(1, 6, 1, 0, 0, 1, 10'b0);
    tbl[11] = mk(0, 0, 0, 1, 0, 1, 10'b0);
    tbl[12] = mk(0, 0, 0, 1, 0, 1, 10'b0);
    tbl[13] = mk(0, 0, 0, 1, 0, 1, 10'b0);
    tbl[14] = mk(0, 0, 0, 1, 1, 1, 10'b1_0110_10_000);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 10'b0);
    #1;
    chk("reset_outputs", {io_bvalid, io_bid, io_bresp, io_aw_full, io_w_stall, io_proto_err}, 16'h0);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].aw, tbl[i].id, tbl[i].len, tbl[i].w, tbl[i].last, tbl[i].br);
      chk($sformatf("tbl%0d", i), obs(), tbl[i].exp);
    end

    do_reset();
    for (int k = 0; k < 4; k++) drive(1, 4'(k), 0, 0, 0, 1);
    chk("aw_full", io_aw_full, 1);
    drive(1, 7, 0, 0, 0, 1);
    chk("aw_overflow_perr", {io_aw_full, io_proto_err}, 2'b11);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 1, 1);
      chk("bid_order", {io_bvalid, io_bid, io_bresp}, {1'b1, 4'(k), 2'b00});
      chk("bid_order_model", obs(), model_exp());
    end

    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 4'(8 + k), 0, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 0);
    end
    chk("w_stall", {io_w_stall, io_bvalid, io_bid}, {2'b11, 4'd8});
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("b_hold", {io_bvalid, io_bid, io_bresp}, {1'b1, 4'd8, 2'b00});
    for (int k = 0; k < 4; k++) begin
      chk("b_drain", {io_bvalid, io_bid}, {1'b1, 4'(8 + k)});
      drive(0, 0, 0, 0, 0, 1);
    end
    chk("b_drained", {io_bvalid, io_w_stall}, 2'b00);

    do_reset();
    drive(0, 0, 0, 1, 1, 1);
    chk("orphan_wlast", {io_bvalid, io_proto_err}, 2'b01);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 1);
      chk("perr_sticky", io_proto_err, 1);
    end

    do_reset();
    drive(1, 9, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 1, 0);
    drive(1, 2, 3, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("pre_reset_state", {io_bvalid, io_bid, io_proto_err}, {1'b1, 4'd9, 1'b1});
    #2 io_rstn = 1'b0;
    #1 chk("async_reset", {io_bvalid, io_bid, io_bresp, io_aw_full, io_w_stall, io_proto_err}, 16'h0);
    io_awvalid = 0; io_awready = 0; io_wvalid = 0; io_wready = 0; io_wlast = 0;
    model_reset();
    @(negedge io_clk);
    io_rstn = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    chk("no_partial", {io_bvalid, io_proto_err}, 2'b00);
    drive(1, 4, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    chk("post_reset_ok", {io_bvalid, io_bid, io_bresp, io_proto_err}, {1'b1, 4'd4, 2'b00, 1'b0});

    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        io_awvalid = $urandom_range(0, 2) != 0;
        io_awready = (aw_q.size() < DEPTH) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
        io_awid = 4'($urandom);
        io_awlen = 8'($urandom_range(0, 3));
        io_wvalid = $urandom_range(0, 1) != 0;
        io_wready = (aw_q.size() > 0 && b_q.size() < DEPTH) ? 1'b1 : ($urandom_range(0, 29) == 0);
        if (aw_q.size() > 0)
          io_wlast = (beats >= int'(aw_q[0].len)) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
        else
          io_wlast = $urandom_range(0, 1) != 0;
        io_bready = $urandom_range(0, 3) != 0;
        tick();
        chk("rand", obs(), model_exp());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
